// File: rtl/mem_dump_pkg.sv
// Shared definitions for the data-memory dump controller: controller states
// and the default geometry of a dump run.
package mem_dump_pkg;

  localparam int unsigned       DEF_DATA_W         = 32;
  localparam int unsigned       DEF_ADDR_W         = 10;
  localparam int unsigned       DEF_PC_W           = 32;
  localparam logic [31:0]       DEF_END_PC         = 32'h0000_008c;
  localparam int unsigned       DEF_BASE_ADDR      = 32;
  localparam int unsigned       DEF_NUM_WORDS      = 96;
  localparam int unsigned       DEF_WORDS_PER_LINE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/mem_dump_ctrl_trigger.sv
// Start-of-dump detector: fires on the cycle pc arrives at END_PC, or on a
// manual force_start.
module dump_trigger
  import mem_dump_pkg::*;
#(
  parameter int unsigned     PC_W   = DEF_PC_W,
  parameter logic [PC_W-1:0] END_PC = PC_W'(DEF_END_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_i,
  input  logic            force_start_i,
  output logic            trig_o
);

  logic [PC_W-1:0] prevPc_q;
  logic            firstCycle_q;
  logic            atEnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevPc_q     <= '0;
      firstCycle_q <= 1'b1;
    end else begin
      prevPc_q     <= pc_i;
      firstCycle_q <= 1'b0;
    end
  end

  // The first-cycle flag lets a pc already sitting at END_PC out of reset count as an arrival.
  assign atEnd  = (pc_i == END_PC);
  assign trig_o = force_start_i | (atEnd & ((prevPc_q != END_PC) | firstCycle_q));

endmodule

// File: rtl/mem_dump_ctrl.sv
// Halts the processor when it reaches END_PC and streams a window of data
// memory out over a valid/ready port, one word per READ/WAIT/SEND round.
module mem_dump_ctrl
  import mem_dump_pkg::*;
#(
  parameter int unsigned     DATA_W         = DEF_DATA_W,
  parameter int unsigned     ADDR_W         = DEF_ADDR_W,
  parameter int unsigned     PC_W           = DEF_PC_W,
  parameter logic [PC_W-1:0] END_PC         = PC_W'(DEF_END_PC),
  parameter int unsigned     BASE_ADDR      = DEF_BASE_ADDR,
  parameter int unsigned     NUM_WORDS      = DEF_NUM_WORDS,
  parameter int unsigned     WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic              force_start,
  input  logic              clear,
  output logic              halt_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_eol,
  output logic              dump_last,
  output logic              done
);

  localparam int unsigned       IDX_W    = $clog2(NUM_WORDS + 1);
  localparam int unsigned       LCNT_W   = $clog2(WORDS_PER_LINE + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [LCNT_W-1:0] LINE_END = LCNT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  dump_state_e       state_q;
  logic [IDX_W-1:0]  wordIdx_q;
  logic [LCNT_W-1:0] lineCnt_q;
  logic              halt_q;
  logic              rdEn_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              eol_q;
  logic              last_q;
  logic              done_q;

  logic              trigger;
  logic              lastWord;
  logic              lineEnd;
  logic [IDX_W-1:0]  idxNext;
  logic [ADDR_W-1:0] addrCur;
  logic [ADDR_W-1:0] addrNext;

  dump_trigger #(
    .PC_W   (PC_W),
    .END_PC (END_PC)
  ) u_trigger (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc),
    .force_start_i (force_start),
    .trig_o        (trigger)
  );

  // A separate in-line counter avoids a modulo by WORDS_PER_LINE.
  assign lastWord = (wordIdx_q == LAST_IDX);
  assign lineEnd  = (lineCnt_q == LINE_END);
  assign idxNext  = wordIdx_q + IDX_W'(1);
  assign addrCur  = BASE_A + ADDR_W'(wordIdx_q);
  assign addrNext = BASE_A + ADDR_W'(idxNext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wordIdx_q <= '0;
      lineCnt_q <= '0;
      halt_q    <= 1'b0;
      rdEn_q    <= 1'b0;
      addr_q    <= BASE_A;
      valid_q   <= 1'b0;
      data_q    <= '0;
      eol_q     <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
          end
        end
        ST_HALT: begin
          state_q <= ST_READ;
          rdEn_q  <= 1'b1;
          addr_q  <= addrCur;
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          rdEn_q  <= 1'b0;
        end
        ST_WAIT: begin
          state_q <= ST_SEND;
          data_q  <= mem_rdata;
          valid_q <= 1'b1;
          eol_q   <= lineEnd | lastWord;
          last_q  <= lastWord;
        end
        ST_SEND: begin
          // Going straight to READ on the handshake keeps the 3-cycle word rate.
          if (dump_ready) begin
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
            if (lastWord) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_READ;
              wordIdx_q <= idxNext;
              lineCnt_q <= lineEnd ? '0 : lineCnt_q + LCNT_W'(1);
              rdEn_q    <= 1'b1;
              addr_q    <= addrNext;
            end
          end
        end
        ST_DONE: begin
          if (clear) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            halt_q    <= 1'b0;
            wordIdx_q <= '0;
            lineCnt_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign halt_req   = halt_q;
  assign mem_rd_en  = rdEn_q;
  assign mem_addr   = addr_q;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_eol   = eol_q;
  assign dump_last  = last_q;
  assign done       = done_q;

endmodule
